// File: rtl/mem_arbiter_bram.sv
// mem_arbiter_bram: arbitrates NUM_PORTS PicoRV32-style requesters onto one single-port 32-bit word memory (ports: clk, reset_n async active-low; per port p: mem_valid[p], mem_addr/mem_wdata[32p+:32], mem_wstrb[4p+:4] in; mem_ready[p], mem_rdata[32p+:32], mem_err[p] out)
module mem_arbiter_bram #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LATENCY = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_PORTS-1:0]      mem_valid,
  input  logic [32*NUM_PORTS-1:0]   mem_addr,
  input  logic [32*NUM_PORTS-1:0]   mem_wdata,
  input  logic [4*NUM_PORTS-1:0]    mem_wstrb,
  output logic [NUM_PORTS-1:0]      mem_ready,
  output logic [32*NUM_PORTS-1:0]   mem_rdata,
  output logic [NUM_PORTS-1:0]      mem_err
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] gnt, last_grant, gnt_c;
  logic [31:0] a_q, wd_q;
  logic [3:0] ws_q;
  logic hit, oor, unused_lsb;
  logic [AW-1:0] widx;
  logic [NUM_PORTS-1:0] rot;
  int base, cand;
  logic [31:0] mem [DEPTH_WORDS];
  assign oor = a_q >= 32'(4 * DEPTH_WORDS);
  assign widx = a_q[AW+1:2];
  assign unused_lsb = ^a_q[1:0];
  always_comb begin
    base = PRIORITY_MODE != 0 ? 0 : (int'(last_grant) + 1) % NUM_PORTS;
    hit = 1'b0;
    gnt_c = '0;
    cand = 0;
    rot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (base + i) % NUM_PORTS;
      rot = mem_valid >> cand;
      if (!hit && rot[0]) begin
        hit = 1'b1;
        gnt_c = PW'(cand);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      gnt <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      a_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
      mem_ready <= '0;
      mem_rdata <= '0;
      mem_err <= '0;
    end else begin
      mem_ready <= '0;
      mem_rdata <= '0;
      mem_err <= '0;
      case (state)
        IDLE: if (hit) begin
          state <= BUSY;
          gnt <= gnt_c;
          last_grant <= gnt_c;
          cnt <= CW'(READ_LATENCY - 1);
          a_q <= mem_addr[32*gnt_c +: 32];
          wd_q <= mem_wdata[32*gnt_c +: 32];
          ws_q <= mem_wstrb[4*gnt_c +: 4];
        end
        BUSY: if (cnt == '0) state <= DONE; else cnt <= cnt - 1'b1;
        DONE: begin
          state <= IDLE;
          mem_ready[gnt] <= 1'b1;
          mem_err[gnt] <= oor;
          mem_rdata[32*gnt +: 32] <= oor ? '0 : mem[widx];
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Write commits only on the first BUSY edge (counter still at its load value); a reset before that edge drops it.
  always_ff @(posedge clk)
    if (state == BUSY && cnt == CW'(READ_LATENCY - 1) && !oor)
      for (int b = 0; b < 4; b++)
        if (ws_q[b]) mem[widx][8*b +: 8] <= wd_q[8*b +: 8];
endmodule

// File: tb/tb_mem_arbiter_bram.sv
// tb_mem_arbiter_bram: directed vector and corner-sequence checks for round-robin, fixed-priority and 3-cycle-latency arbiters
module tb_mem_arbiter_bram;
  typedef struct {
    int p;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] ws;
    logic [31:0] rd;
    logic er;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] v [3];
  logic [63:0] addr, wdata;
  logic [7:0] wstrb;
  logic [1:0] rdy [3];
  logic [63:0] rdat [3];
  logic [1:0] er [3];
  int checks = 0;
  int errors = 0;
  vec_t tv [14];
  always #5 clk = ~clk;
  mem_arbiter_bram #(.NUM_PORTS(2), .DEPTH_WORDS(1024), .READ_LATENCY(1), .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .mem_valid(v[0]), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy[0]), .mem_rdata(rdat[0]), .mem_err(er[0]));
  mem_arbiter_bram #(.NUM_PORTS(2), .DEPTH_WORDS(1024), .READ_LATENCY(1), .PRIORITY_MODE(1)) u_fx (
    .clk(clk), .reset_n(reset_n), .mem_valid(v[1]), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy[1]), .mem_rdata(rdat[1]), .mem_err(er[1]));
  mem_arbiter_bram #(.NUM_PORTS(2), .DEPTH_WORDS(1024), .READ_LATENCY(3), .PRIORITY_MODE(0)) u_l3 (
    .clk(clk), .reset_n(reset_n), .mem_valid(v[2]), .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(rdy[2]), .mem_rdata(rdat[2]), .mem_err(er[2]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic xact(input int d, input int p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp_rd, input logic exp_er, input int exp_n, input string nm);
    int n = 0;
    @(negedge clk);
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = wd;
    wstrb[4*p +: 4] = ws;
    v[d][p] = 1'b1;
    while (n < 20 && rdy[d][p] !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    v[d][p] = 1'b0;
    chk({nm, " latency"}, n, exp_n);
    chk({nm, " rdata"}, rdat[d][32*p +: 32], exp_rd);
    chk({nm, " err"}, 32'(er[d][p]), 32'(exp_er));
    chk({nm, " other ready"}, 32'(rdy[d][1-p]), 0);
    @(posedge clk);
    #1;
    chk({nm, " ready width"}, 32'(rdy[d]), 0);
    chk({nm, " idle outputs"}, 32'(|rdat[d] | |er[d]), 0);
  endtask
  task automatic contend(input int d, input int e0, input int e1, input string nm);
    int ord [2] = '{-1, -1};
    int k = 0;
    int n = 0;
    int both = 0;
    @(negedge clk);
    addr = {32'h400, 32'h400};
    wstrb = '0;
    v[d] = 2'b11;
    while (k < 2 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy[d] == 2'b11) both++;
      for (int q = 0; q < 2; q++)
        if (rdy[d][q] === 1'b1 && k < 2) begin
          ord[k] = q;
          k++;
          v[d][q] = 1'b0;
        end
    end
    v[d] = '0;
    chk({nm, " first grant"}, ord[0], e0);
    chk({nm, " second grant"}, ord[1], e1);
    chk({nm, " one-hot ready"}, both, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask
  task automatic abort_after_grant(input int p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input string nm);
    logic seen = 1'b0;
    @(negedge clk);
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = wd;
    wstrb[4*p +: 4] = ws;
    v[0][p] = 1'b1;
    @(posedge clk);
    #1;
    v[0][p] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({nm, " ready in reset"}, 32'(rdy[0]), 0);
    #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | rdy[0][p];
    end
    chk({nm, " no completion"}, 32'(seen), 0);
  endtask
  initial begin
    for (int d = 0; d < 3; d++) v[d] = '0;
    addr = '0;
    wdata = '0;
    wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ready d%0d", d), 32'(rdy[d]), 0);
      chk($sformatf("reset rdata/err d%0d", d), 32'(|rdat[d] | |er[d]), 0);
    end
    reset_n = 1'b1;
    tv[0]  = '{1, 32'h0000_0400, 32'd42,         4'hF, 32'd42,         1'b0};
    tv[1]  = '{0, 32'h0000_0400, 32'h0,          4'h0, 32'd42,         1'b0};
    tv[2]  = '{0, 32'h0000_0404, 32'h1234_5014,  4'hF, 32'h1234_5014,  1'b0};
    tv[3]  = '{1, 32'h0000_0404, 32'h0000_AB00,  4'h2, 32'h1234_AB14,  1'b0};
    tv[4]  = '{0, 32'h0000_0404, 32'h0,          4'h0, 32'h1234_AB14,  1'b0};
    tv[5]  = '{1, 32'h0000_0407, 32'h0,          4'h0, 32'h1234_AB14,  1'b0};
    tv[6]  = '{1, 32'h0000_0000, 32'hCAFE_F00D,  4'hF, 32'hCAFE_F00D,  1'b0};
    tv[7]  = '{0, 32'h0000_1000, 32'hFFFF_FFFF,  4'hF, 32'h0,          1'b1};
    tv[8]  = '{1, 32'h0000_1000, 32'h0,          4'h0, 32'h0,          1'b1};
    tv[9]  = '{0, 32'h0000_0000, 32'h0,          4'h0, 32'hCAFE_F00D,  1'b0};
    tv[10] = '{1, 32'h0000_0FFC, 32'h1122_3344,  4'hF, 32'h1122_3344,  1'b0};
    tv[11] = '{0, 32'h0000_0FFC, 32'hAABB_CCDD,  4'h9, 32'hAA22_33DD,  1'b0};
    tv[12] = '{1, 32'hFFFF_FFFC, 32'h0,          4'h0, 32'h0,          1'b1};
    tv[13] = '{0, 32'h0000_0FFC, 32'h0,          4'h0, 32'hAA22_33DD,  1'b0};
    for (int i = 0; i < 14; i++)
      xact(0, tv[i].p, tv[i].a, tv[i].wd, tv[i].ws, tv[i].rd, tv[i].er, 3, $sformatf("vec%0d", i));
    abort_after_grant(0, 32'h404, 32'h0, 4'h0, "abort read");
    xact(0, 0, 32'h404, 32'h0, 4'h0, 32'h1234_AB14, 1'b0, 3, "read after reset");
    abort_after_grant(1, 32'h0, 32'h0BAD_BEEF, 4'hF, "abort write");
    xact(0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 3, "word0 after aborted write");
    pulse_reset();
    contend(0, 0, 1, "rr round1");
    xact(0, 0, 32'h400, 32'd42, 4'hF, 32'd42, 1'b0, 3, "rr single p0");
    contend(0, 1, 0, "rr round2");
    contend(1, 0, 1, "fixed round1");
    xact(1, 0, 32'h400, 32'd42, 4'hF, 32'd42, 1'b0, 3, "fixed single p0");
    contend(1, 0, 1, "fixed round2");
    xact(2, 0, 32'h10, 32'h55AA_00FF, 4'hF, 32'h55AA_00FF, 1'b0, 5, "lat3 write");
    xact(2, 1, 32'h10, 32'h0, 4'h0, 32'h55AA_00FF, 1'b0, 5, "lat3 read");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
